imem_boot_loader: RTL



---
 rtl/imem_boot_loader_pkg.sv | 21 ++
 rtl/imem_loader_timeout.sv | 33 +++
 rtl/imem_boot_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the serial instruction-memory boot loader:
// FSM state encoding, the default frame marker and the checksum step.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // 8-bit wrap-around running sum used for the frame checksum
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Clearable inter-byte timeout counter: counts enabled idle clocks and flags
// expiry once CYCLES-1 clocks have elapsed since the last clear.
module imem_loader_timeout #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    assign expired = enable && (count == LAST);

    // Elapsed-clock register; saturates at LAST so expiry stays asserted
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian words into
// instruction memory from address 0, checks the checksum and restarts the CPU.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  cpu_restart,
    output logic                  load_done,
    output logic                  load_error
);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] word_cnt, word_cnt_n;
    logic [1:0]            byte_cnt, byte_cnt_n;
    logic [31:0]           shift, shift_n;
    logic [7:0]            csum, csum_n;
    logic                  we_n, restart_n, hold_n, done_n, error_n;
    logic [ADDR_WIDTH-1:0] waddr_n;
    logic [31:0]           wdata_n;
    logic                  in_frame, expired;

    assign in_frame = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CSUM);

    imem_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid || !in_frame),
        .enable  (in_frame),
        .expired (expired)
    );

    // Next-state and next-output logic for the frame parser
    always_comb begin
        state_n    = state;
        word_cnt_n = word_cnt;
        byte_cnt_n = byte_cnt;
        shift_n    = shift;
        csum_n     = csum;
        we_n       = 1'b0;
        restart_n  = 1'b0;
        hold_n     = cpu_hold;
        done_n     = load_done;
        error_n    = load_error;
        wdata_n    = imem_wdata;
        // The address advances only after its write cycle has been presented
        if (imem_we) begin
            waddr_n = imem_waddr + ADDR_WIDTH'(1);
        end else begin
            waddr_n = imem_waddr;
        end

        case (state)
            ST_IDLE, ST_ERROR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_n = ST_COUNT;
                    hold_n  = 1'b1;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    csum_n  = 8'd0;
                end else begin
                    state_n = state;
                end
            end
            ST_COUNT: begin
                if (rx_valid) begin
                    word_cnt_n = ADDR_WIDTH'(rx_data);
                    csum_n     = csum_add(csum, rx_data);
                    waddr_n    = '0;
                    byte_cnt_n = 2'd0;
                    state_n    = ST_DATA;
                end else if (expired) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end else begin
                    state_n = ST_COUNT;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    shift_n    = {shift[23:0], rx_data};
                    csum_n     = csum_add(csum, rx_data);
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        we_n       = 1'b1;
                        wdata_n    = {shift[23:0], rx_data};
                        word_cnt_n = word_cnt - ADDR_WIDTH'(1);
                        state_n    = (word_cnt == '0) ? ST_CSUM : ST_DATA;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else if (expired) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (rx_valid && (rx_data == csum)) begin
                    state_n   = ST_DONE;
                    hold_n    = 1'b0;
                    restart_n = 1'b1;
                    done_n    = 1'b1;
                end else if (rx_valid || expired) begin
                    state_n = ST_ERROR;
                    error_n = 1'b1;
                end else begin
                    state_n = ST_CSUM;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered-output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            byte_cnt    <= 2'd0;
            shift       <= 32'd0;
            csum        <= 8'd0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= 32'd0;
            cpu_hold    <= 1'b0;
            cpu_restart <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            state       <= state_n;
            word_cnt    <= word_cnt_n;
            byte_cnt    <= byte_cnt_n;
            shift       <= shift_n;
            csum        <= csum_n;
            imem_we     <= we_n;
            imem_waddr  <= waddr_n;
            imem_wdata  <= wdata_n;
            cpu_hold    <= hold_n;
            cpu_restart <= restart_n;
            load_done   <= done_n;
            load_error  <= error_n;
        end
    end

endmodule
